// File: rtl/load_pkg.sv
// Shared types for the load data unit: funct3 load codes, FSM states and
// the alignment rule used to reject a load before any memory traffic.
package load_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_ILL = 3'b111
  } load_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_EXT  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4,
    S_TOUT = 3'd5
  } state_t;

  // True when the access cannot be served: illegal code or an offset that
  // is not a multiple of the access size.
  function automatic logic is_misaligned(load_t f, logic [2:0] off);
    logic bad;
    case (f)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW, F3_LWU: bad = (off[1:0] != 2'b00);
      F3_LD:         bad = (off != 3'b000);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half/word/double extraction from a 64-bit memory word,
// followed by sign or zero extension according to the load type.
module load_extend
  import load_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Align the addressed field to bit 0, then keep and extend it.
  always_comb begin
    shifted = raw >> {off, 3'b000};
    result  = 64'h0;
    case (load_t'(funct3))
      F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   result = shifted;
      F3_LBU:  result = {56'h0, shifted[7:0]};
      F3_LHU:  result = {48'h0, shifted[15:0]};
      F3_LWU:  result = {32'h0, shifted[31:0]};
      default: result = 64'h0;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Multicycle load stage: checks alignment, requests a doubleword, waits for
// mem_ready with a bounded timeout, extracts/extends the addressed field and
// holds it in data_out for the write-back select.
// Handshake: mem_rd_req is held high for every REQ cycle; the word is taken
// in the first REQ cycle where mem_ready is high, and mem_ready seen in any
// other state is ignored. done is a one-cycle pulse; err_* qualify it.
module load_data_unit
  import load_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  localparam int WAIT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_off,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd_req,
  output logic        busy,
  output logic        done,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic [63:0] data_out,
  output logic [2:0]  dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state;
  logic [2:0]        f3_q;
  logic [2:0]        off_q;
  logic [63:0]       raw_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic [63:0]       ext_data;

  assign wait_next = wait_cnt + WAIT_W'(1);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  load_extend u_extend (
    .raw    (raw_q),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  // Load sequencer with registered request, pulse and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      f3_q         <= 3'b000;
      off_q        <= 3'b000;
      raw_q        <= 64'h0;
      wait_cnt     <= '0;
      mem_rd_req   <= 1'b0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      data_out     <= 64'h0;
    end else begin
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      mem_rd_req   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q     <= funct3;
            off_q    <= addr_off;
            wait_cnt <= '0;
            if (is_misaligned(load_t'(funct3), addr_off)) begin
              state <= S_ERR;
            end else begin
              state      <= S_REQ;
              mem_rd_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            // Ready wins even on the cycle the wait budget runs out.
            raw_q    <= mem_rdata;
            wait_cnt <= '0;
            state    <= S_EXT;
          end else if (wait_next == WAIT_LIMIT) begin
            wait_cnt    <= wait_next;
            state       <= S_TOUT;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt   <= wait_next;
            mem_rd_req <= 1'b1;
          end
        end
        S_EXT: begin
          data_out <= ext_data;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERR: begin
          // Rejected before any memory request; result register untouched.
          done         <= 1'b1;
          err_misalign <= 1'b1;
          state        <= S_IDLE;
        end
        S_TOUT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_unit.sv
// Directed bench for load_data_unit: each step drives one load, counts the
// request cycles, finds the done pulse, and checks timing, flags and data.
module tb_load_data_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [2:0]  addr_off;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd_req;
  logic        busy;
  logic        done;
  logic        err_misalign;
  logic        err_timeout;
  logic [63:0] data_out;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  load_data_unit #(.MAX_WAIT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .funct3       (funct3),
    .addr_off     (addr_off),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_rd_req   (mem_rd_req),
    .busy         (busy),
    .done         (done),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .data_out     (data_out),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one load starting in the current cycle (cycle 0). ready_at is the
  // cycle index from which mem_ready is driven high (0 = never). stray puts a
  // second start pulse in cycle 1. Expected data comes from exp_q.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                          input logic [63:0] rdata, input int ready_at, input logic stray,
                          input int exp_done, input int exp_req,
                          input logic exp_mis, input logic exp_tout);
    int req_cnt = 0;
    int done_cyc = -1;
    logic mis_seen = 1'b0;
    logic tout_seen = 1'b0;
    logic [63:0] exp_data;
    start     = 1'b1;
    funct3    = f3;
    addr_off  = off;
    mem_rdata = rdata;
    mem_ready = (ready_at == 0) ? 1'b0 : (ready_at <= 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_rd_req) req_cnt++;
      if (done && done_cyc < 0) begin
        done_cyc  = c;
        mis_seen  = err_misalign;
        tout_seen = err_timeout;
      end
      start     = stray && (c == 1);
      mem_ready = (ready_at != 0) && (c >= ready_at);
      if (done_cyc >= 0) break;
    end
    start     = 1'b0;
    mem_ready = 1'b0;
    exp_data  = exp_q.pop_front();
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, "_req_cycles"}, 64'(req_cnt), 64'(exp_req));
    check({tag, "_err_misalign"}, {63'h0, mis_seen}, {63'h0, exp_mis});
    check({tag, "_err_timeout"}, {63'h0, tout_seen}, {63'h0, exp_tout});
    check({tag, "_data_out"}, data_out, exp_data);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {63'h0, done}, 64'h0);
    check({tag, "_idle_after"}, {63'h0, busy}, 64'h0);
  endtask

  // Directed sequence
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    funct3    = 3'b000;
    addr_off  = 3'b000;
    mem_rdata = 64'h0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {61'h0, dbg_state}, 64'h0);
    check("rst_req", {63'h0, mem_rd_req}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_errs", {62'h0, err_misalign, err_timeout}, 64'h0);
    check("rst_data", data_out, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
    run_load("lb_off3", 3'b000, 3'd3, 64'h0000_0000_8000_0000, 1, 1'b0, 3, 1, 1'b0, 1'b0);

    exp_q.push_back(64'h0000_0000_0000_BEEF);
    run_load("lhu_off6", 3'b101, 3'd6, 64'hBEEF_0000_0000_0000, 1, 1'b0, 3, 1, 1'b0, 1'b0);

    exp_q.push_back(64'hFFFF_FFFF_8765_4321);
    run_load("lw_wait2", 3'b010, 3'd4, 64'h8765_4321_0000_0000, 3, 1'b1, 5, 3, 1'b0, 1'b0);

    exp_q.push_back(64'hFFFF_FFFF_8765_4321);
    run_load("ld_mis", 3'b011, 3'd2, 64'h1111_2222_3333_4444, 1, 1'b0, 2, 0, 1'b1, 1'b0);

    exp_q.push_back(64'hFFFF_FFFF_8765_4321);
    run_load("ill_f3", 3'b111, 3'd0, 64'h1111_2222_3333_4444, 1, 1'b0, 2, 0, 1'b1, 1'b0);

    exp_q.push_back(64'hFFFF_FFFF_8765_4321);
    run_load("ld_tout", 3'b011, 3'd0, 64'h5555_6666_7777_8888, 0, 1'b0, 16, 15, 1'b0, 1'b1);

    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    run_load("ld_retry", 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 3, 1, 1'b0, 1'b0);

    exp_q.push_back(64'h0000_0000_F00D_CAFE);
    run_load("lwu_last", 3'b110, 3'd0, 64'h1234_5678_F00D_CAFE, 15, 1'b0, 17, 15, 1'b0, 1'b0);

    exp_q.push_back(64'h0000_0000_0000_7FFF);
    run_load("lh_off2", 3'b001, 3'd2, 64'h0000_0000_7FFF_0000, 1, 1'b0, 3, 1, 1'b0, 1'b0);

    exp_q.push_back(64'h0000_0000_0000_00A5);
    run_load("lbu_off7", 3'b100, 3'd7, 64'hA5FF_FFFF_FFFF_FFFF, 1, 1'b0, 3, 1, 1'b0, 1'b0);

    // Reset in the second REQ cycle with a stray start alongside it.
    start     = 1'b1;
    funct3    = 3'b010;
    addr_off  = 3'd0;
    mem_rdata = 64'h0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("mid_req1", {63'h0, mem_rd_req}, 64'h1);
    start = 1'b1;
    @(negedge clk);
    check("mid_req2", {63'h0, mem_rd_req}, 64'h1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("mid_rst_state", {61'h0, dbg_state}, 64'h0);
    check("mid_rst_req", {63'h0, mem_rd_req}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_data", data_out, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", {63'h0, done}, 64'h0);
      check("mid_rst_stay_idle", {63'h0, busy}, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
